// File: rtl/uart_tx_fifo_if.sv
// Host/uart-facing signal bundle for the transmit byte queue.
// slave is the queue itself; master is whoever drives bytes and models the uart.
interface uart_tx_fifo_if #(parameter int AW = 4);
    logic          push;
    logic [7:0]    push_data;
    logic          flush;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          overflow;
    logic [7:0]    uart_din;
    logic          uart_wr_en;
    logic          uart_wr_rdy;

    modport master (
        output push, push_data, flush, uart_wr_rdy,
        input  full, empty, level, overflow, uart_din, uart_wr_en
    );

    modport slave (
        input  push, push_data, flush, uart_wr_rdy,
        output full, empty, level, overflow, uart_din, uart_wr_en
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding a uart transmitter; a small FSM hands each stored byte
// to the uart exactly once over the din / wr_en / wr_rdy handshake.
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    state_e        state_q;
    logic [7:0]    din_q;
    logic          wr_en_q;
    logic          ovf_q;
    logic [TW-1:0] tmo_q;

    logic full, empty, push_ok, pop_ok;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_ok = bus.push && !full && !bus.flush;
    assign pop_ok  = (state_q == IDLE) && !empty && bus.uart_wr_rdy && !bus.flush;

    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.level      = wr_ptr_q - rd_ptr_q;
    assign bus.overflow   = ovf_q;
    assign bus.uart_din   = din_q;
    assign bus.uart_wr_en = wr_en_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        // Flush compares against the pre-edge write pointer; a same-cycle push is dropped.
        if (bus.flush)   rd_ptr_d = wr_ptr_q;
        else if (pop_ok) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= bus.push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            din_q   <= 8'h00;
            wr_en_q <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            ovf_q   <= bus.push && full && !bus.flush;
            wr_en_q <= 1'b0;
            if (bus.flush) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (pop_ok) begin
                        din_q   <= mem_q[rd_ptr_q[AW-1:0]];
                        wr_en_q <= 1'b1;
                        state_q <= SEND;
                    end
                    SEND: begin
                        tmo_q   <= '0;
                        state_q <= WAIT_BUSY;
                    end
                    // A uart that never drops wr_rdy still consumed the byte; give up
                    // after BUSY_TIMEOUT cycles spent here.
                    WAIT_BUSY: begin
                        if (!bus.uart_wr_rdy)                        state_q <= WAIT_DONE;
                        else if (tmo_q == TW'(BUSY_TIMEOUT - 1))     state_q <= IDLE;
                        else                                          tmo_q   <= tmo_q + TW'(1);
                    end
                    WAIT_DONE: if (bus.uart_wr_rdy) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule
